// File: rtl/axi3_rd_responder_pkg.sv
// Shared AXI3 read-channel types, encodings and responder state type.
// Imported by the interface, the responder and the bench.
package axi3_rd_responder_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    RS_IDLE,
    RS_BURST
  } rs_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [29:0]         waddr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi3_ar_t;

  // Only 4-byte FIXED/INCR bursts are served; everything else answers SLVERR.
  function automatic logic burst_is_err(input logic [1:0] burst, input logic [2:0] size);
    return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != SIZE_4B);
  endfunction

endpackage

// File: rtl/axi3_rd_if.sv
// AXI3 read address + read data channel bundle.
// slave modport faces the responder, master modport faces the requester.
interface axi3_rd_if;
  import axi3_rd_responder_pkg::*;

  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/sync_ram_sp.sv
// Single-port RAM, synchronous read, 1-cycle latency, enable-gated access.
// No backpressure; rdata holds its last value while en is low.
module sync_ram_sp #(
  parameter int DEPTH     = 1024,
  parameter int WIDTH     = 32,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents come from the implementation flow's memory-init mechanism when INIT_FILE is set.
  logic unused_init_file;
  assign unused_init_file = ^INIT_FILE;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/axi3_rd_responder.sv
// AXI3 read responder over a word RAM, one burst outstanding; first R beat 2 cycles after AR.
// One beat per cycle with rready high; R outputs and RAM enable freeze while rvalid & !rready.
module axi3_rd_responder
  import axi3_rd_responder_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter     MEM_INIT  = ""
) (
  input logic      clk,
  input logic      rst,
  axi3_rd_if.slave axi3_rd_if
);

  localparam int AW = $clog2(MEM_DEPTH);

  rs_state_t     state_q, state_d;
  axi3_ar_t      ar_q;
  logic [4:0]    beat_q;
  logic          rvalid_q, rlast_q;
  logic [1:0]    rresp_q;
  logic [AXI_ID_W-1:0] rid_q;
  logic          ar_hs, adv, beats_left, err;
  logic [AW-1:0] ram_addr;
  logic [AXI_DATA_W-1:0] ram_rdata;

  assign ar_hs      = axi3_rd_if.arvalid && (state_q == RS_IDLE);
  assign err        = burst_is_err(ar_q.burst, ar_q.size);
  assign beats_left = beat_q <= {1'b0, ar_q.len};
  assign adv        = (state_q == RS_BURST) && beats_left && (!rvalid_q || axi3_rd_if.rready);
  // Linear increment with silent wrap at MEM_DEPTH; no 4 KB boundary handling.
  assign ram_addr   = ar_q.waddr[AW-1:0] + ((ar_q.burst == BURST_INCR) ? AW'(beat_q) : '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RS_IDLE:  if (axi3_rd_if.arvalid) state_d = RS_BURST;
      RS_BURST: if (rvalid_q && rlast_q && axi3_rd_if.rready) state_d = RS_IDLE;
      default:  state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q     <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= '0;
    end else begin
      if (ar_hs) begin
        ar_q   <= '{id: axi3_rd_if.arid, waddr: axi3_rd_if.araddr[31:2], len: axi3_rd_if.arlen,
                    size: axi3_rd_if.arsize, burst: axi3_rd_if.arburst};
        beat_q <= '0;
      end
      if (adv) begin
        beat_q   <= beat_q + 5'd1;
        rvalid_q <= 1'b1;
        rlast_q  <= (beat_q[3:0] == ar_q.len);
        rresp_q  <= err ? RESP_SLVERR : RESP_OKAY;
        rid_q    <= ar_q.id;
      end else if (axi3_rd_if.rready) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  sync_ram_sp #(
    .DEPTH     (MEM_DEPTH),
    .WIDTH     (AXI_DATA_W),
    .INIT_FILE (MEM_INIT)
  ) u_ram (
    .clk   (clk),
    .en    (adv),
    .we    (1'b0),
    .addr  (ram_addr),
    .wdata ('0),
    .rdata (ram_rdata)
  );

  assign axi3_rd_if.arready = (state_q == RS_IDLE);
  assign axi3_rd_if.rvalid  = rvalid_q;
  assign axi3_rd_if.rlast   = rlast_q;
  assign axi3_rd_if.rresp   = rresp_q;
  assign axi3_rd_if.rid     = rid_q;
  assign axi3_rd_if.rdata   = (rresp_q == RESP_SLVERR) ? '0 : ram_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi3_rd_if.araddr[1:0], (ar_q.waddr >> AW)};

endmodule

// File: tb/tb_axi3_rd_responder.sv
// Directed bench for axi3_rd_responder: table of bursts with hand-computed data,
// plus a mid-burst reset sequence. RAM preloaded with word[i] = i.
module tb_axi3_rd_responder;
  import axi3_rd_responder_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  axi3_rd_if bus ();

  axi3_rd_responder #(.MEM_DEPTH(1024), .MEM_INIT("")) dut (
    .clk        (clk),
    .rst        (rst),
    .axi3_rd_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  id;
    bit          stall;
    logic [31:0] exp_base;
    int          exp_step;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, output bit ok);
    int n;
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arsize  = size;
    bus.arid    = id;
    n = 0;
    while (!bus.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.arready;
    if (!ok) begin
      check("ar_accept_timeout", 32'(bus.arready), 32'd1);
      bus.arvalid = 1'b0;
    end
  endtask

  task automatic run_burst(input int vi, input vec_t v);
    bit   ok, got_first, rr;
    int   k, nbeat, first_k;
    logic [31:0] exp_d;
    issue_ar(v.addr, v.len, v.burst, v.size, v.id, ok);
    if (!ok) return;
    k = 0; nbeat = 0; first_k = -1; got_first = 0;
    while (nbeat < int'(v.len) + 1 && k < 200) begin
      @(negedge clk);
      if (k == 0) bus.arvalid = 1'b0;
      k++;
      rr = v.stall ? ((k - 1) % 3 == 0) : 1'b1;
      bus.rready = rr;
      if (bus.rvalid && !got_first) begin
        got_first = 1;
        first_k   = k;
      end
      if (bus.rvalid && rr) begin
        exp_d = (v.exp_base + 32'(v.exp_step * nbeat)) % 32'd1024;
        check($sformatf("v%0d b%0d rdata", vi, nbeat), bus.rdata, exp_d);
        check($sformatf("v%0d b%0d rid", vi, nbeat), 32'(bus.rid), 32'(v.id));
        check($sformatf("v%0d b%0d rresp", vi, nbeat), 32'(bus.rresp), 32'(v.exp_resp));
        check($sformatf("v%0d b%0d rlast", vi, nbeat), 32'(bus.rlast), 32'(nbeat == int'(v.len)));
        nbeat++;
      end
    end
    check($sformatf("v%0d beat_count", vi), 32'(nbeat), 32'(int'(v.len) + 1));
    check($sformatf("v%0d first_rvalid_latency", vi), 32'(first_k), 32'd2);
    @(negedge clk);
    bus.rready = 1'b0;
    check($sformatf("v%0d arready_after_last", vi), 32'(bus.arready), 32'd1);
    check($sformatf("v%0d rvalid_after_last", vi), 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k, seen;
    vecs[0] = '{32'h40,  4'd7,  BURST_INCR,  SIZE_4B, 4'd2,  1'b0, 32'h10,  1, RESP_OKAY};
    vecs[1] = '{32'h40,  4'd7,  BURST_INCR,  SIZE_4B, 4'd2,  1'b1, 32'h10,  1, RESP_OKAY};
    vecs[2] = '{32'h20,  4'd3,  BURST_FIXED, SIZE_4B, 4'd5,  1'b0, 32'h08,  0, RESP_OKAY};
    vecs[3] = '{32'h0,   4'd1,  BURST_WRAP,  SIZE_4B, 4'd1,  1'b0, 32'h0,   0, RESP_SLVERR};
    vecs[4] = '{32'h100, 4'd2,  BURST_INCR,  SIZE_4B, 4'd3,  1'b1, 32'h40,  1, RESP_OKAY};
    vecs[5] = '{32'hFFC, 4'd1,  BURST_INCR,  SIZE_4B, 4'd7,  1'b0, 32'h3FF, 1, RESP_OKAY};
    vecs[6] = '{32'h40,  4'd0,  BURST_INCR,  3'b011,  4'd4,  1'b0, 32'h0,   0, RESP_SLVERR};
    vecs[7] = '{32'h80,  4'd2,  2'b11,       SIZE_4B, 4'd6,  1'b1, 32'h0,   0, RESP_SLVERR};
    vecs[8] = '{32'hF00, 4'd15, BURST_INCR,  SIZE_4B, 4'd15, 1'b1, 32'h3C0, 1, RESP_OKAY};

    for (int i = 0; i < 1024; i++) dut.u_ram.mem[i] = 32'(i);

    rst = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0;
    bus.arsize = '0; bus.arid = '0; bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rvalid", 32'(bus.rvalid), 32'd0);
    check("reset rlast", 32'(bus.rlast), 32'd0);
    check("reset rresp", 32'(bus.rresp), 32'd0);
    check("reset rid", 32'(bus.rid), 32'd0);
    check("reset arready", 32'(bus.arready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_burst(i, vecs[i]);

    // Reset after beat 2 of a 16-beat burst aborts the rest of it.
    issue_ar(32'h0, 4'd15, BURST_INCR, SIZE_4B, 4'd9, ok);
    if (ok) begin
      k = 0; seen = 0;
      while (seen < 3 && k < 50) begin
        @(negedge clk);
        if (k == 0) bus.arvalid = 1'b0;
        k++;
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          check($sformatf("abort b%0d rdata", seen), bus.rdata, 32'(seen));
          seen++;
        end
      end
      check("abort beats_before_reset", 32'(seen), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check("abort rvalid_in_reset", 32'(bus.rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort arready_after_release", 32'(bus.arready), 32'd1);
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.rvalid) seen++;
      end
      check("abort no_stray_beats", 32'(seen), 32'd0);
      bus.rready = 1'b0;
      run_burst(9, vecs[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axi3_rd_responder.md
AXI3_RD_RESPONDER -- requirements
Module: axi3_rd_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, the number of 32-bit words in backing memory (power of two).
REQ-002 SHALL have parameter MEM_INIT, default "", the hex file loaded at elaboration; empty means all words zero.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port axi3_rd_if  axi3_rd_if.slave  bundle  AXI3 read channel; drives arready, rid, rdata, rresp, rlast, rvalid; samples arid, araddr, arlen, arsize, arburst, arvalid, rready.

Function
REQ-006 SHALL be a two-state FSM, RS_IDLE then RS_BURST, with RS_IDLE entered out of reset.
REQ-007 SHALL drive arready=1 only in RS_IDLE, so that at most one burst is outstanding.
REQ-008 SHALL, on an AR handshake (arvalid&arready), latch arid, word address araddr[31:2], arlen, arsize and arburst, clear the beat counter, and enter RS_BURST.
REQ-009 SHALL advance the pipeline when (!rvalid | rready) in RS_BURST and beats remain to be issued, and each advance SHALL issue one RAM read.
REQ-010 SHALL index RAM by word address modulo MEM_DEPTH, so out-of-range addresses wrap silently.
REQ-011 SHALL use 1-cycle RAM read latency; first rvalid SHALL assert 2 cycles after the AR handshake cycle.
REQ-012 SHALL hold rdata, rid, rresp and rlast stable while rvalid=1 and rready=0; RAM enable SHALL be 0 while stalled.
REQ-013 SHALL sustain one beat per cycle while rready is held high.
REQ-014 SHALL, for INCR (2'b01), increment the word address by 1 per beat; for FIXED (2'b00), hold the address constant.
REQ-015 SHALL return rresp=2'b10 (SLVERR) and rdata=0 on every beat when arburst is WRAP or reserved, or when arsize!=3'b010, still delivering arlen+1 beats.
REQ-016 SHALL otherwise return rresp=2'b00.
REQ-017 SHALL set rid to the latched arid on every beat.
REQ-018 SHALL assert rlast exactly on beat index arlen (0..15).
REQ-019 SHALL return to RS_IDLE on the cycle after the rlast beat handshakes, with arready=1 in that cycle.
REQ-020 SHALL NOT check 4 KB boundary crossing; addresses SHALL be incremented linearly.
REQ-021 SHALL ignore arvalid while in RS_BURST; the master SHALL keep the request pending until arready.

Reset
REQ-022 SHALL, while rst=1, clear: state to RS_IDLE, rvalid=0, rlast=0, rresp=0, rid=0, and beat/issue counters to 0.
REQ-023 SHALL treat reset mid-burst as an abort: rvalid low on the next cycle, no remaining beats delivered, arready=1 on the first cycle after reset release.
REQ-024 SHALL leave memory contents unaffected by reset.

Structure
REQ-025 SHALL declare the rs_state_t enum in the shared cache-utils header, beside the existing stream-buffer state type.
REQ-026 SHALL take AXI3 request/response typedefs and burst/size encodings from the existing shared package; no local redefinition.
REQ-027 SHALL instantiate one sub-module sync_ram_sp: single-port, synchronous-read, read-enable gated, parameters DEPTH, WIDTH=32, INIT_FILE.
REQ-028 SHALL keep the RTL within 120-400 lines excluding sync_ram_sp.

Verification
REQ-029 Scenario: MEM_INIT word[i]=i; AR araddr=0x40, arlen=7, INCR, size 4B, arid=2, rready=1 -> 8 beats rdata 0x10..0x17 on consecutive cycles, rid=2, rresp=0, rlast on beat 7, first rvalid 2 cycles after the handshake.
REQ-030 Scenario: same burst with rready toggled 1,0,0,1,... -> data held while stalled, no beat lost or duplicated, order 0x10..0x17.
REQ-031 Scenario: araddr=0x20, arlen=3, FIXED -> 4 beats all 0x08, rlast on beat 3.
REQ-032 Scenario: arburst=2'b10 (WRAP), arlen=1 -> 2 beats rdata=0, rresp=2'b10; next INCR burst returns OKAY.
REQ-033 Scenario: MEM_DEPTH=1024, araddr=0xFFC, arlen=1 INCR -> beats word[1023], word[0].
REQ-034 Scenario: rst=1 after beat 2 of a 16-beat burst -> rvalid=0 the next cycle; arready=1 the cycle after rst deasserts; a fresh burst completes correctly.
